// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-write signals.
// The slave modport is the loader's view; the master modport is the host/bench side.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              abort;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [2:0]        dbg_state;

    // Byte handshake: a byte moves on every cycle where rx_valid and rx_ready are
    // both high; rx_valid may drop or stall for any length without loss.
    modport slave (
        input  start, word_count, abort, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error,
               dbg_state
    );

    modport master (
        output start, word_count, abort, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error,
               dbg_state
    );
endinterface

// File: rtl/imem_loader.sv
// Loads word_count 16-bit instructions, high byte first, from a byte stream
// into the instruction memory while holding the CPU stalled.
module imem_loader #(
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              count_ok;
    logic              xfer;
    logic              last_word;

    // Legal counts are 1..2**ADDR_W: non-zero, and if the top bit is set the rest must be zero.
    assign count_ok  = (bus.word_count != '0) &&
                       (!bus.word_count[ADDR_W] || (bus.word_count[ADDR_W-1:0] == '0));
    assign xfer      = bus.rx_valid && rx_ready_q;
    assign last_word = ({1'b0, idx_q} == (count_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (count_ok) begin
                        error_d = 1'b0;
                        count_d = bus.word_count;
                        idx_d   = '0;
                        state_d = S_HI;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (bus.abort) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    hi_d    = bus.rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (bus.abort) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    // Word and address change together so both hold steady between writes.
                    wdata_d = {hi_q, bus.rx_data};
                    addr_d  = 16'({idx_q, 1'b0});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_HI) || (state_d == S_LO);
        busy_d     = (state_d != S_IDLE);
        we_d       = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // An abort landing in WRITE must kill the strobe in that same cycle.
    assign bus.mem_we    = we_q && !bus.abort;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rx_ready  = rx_ready_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_hold  = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a queue as stimulus
// is issued, and a negedge monitor pops and compares every mem_we strobe.
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LO   = 3'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -1;
  int   k0 = 0;
  int   dc = 0;
  logic busy_hist [0:1023];

  logic [31:0] exp_q[$];
  int          exp_t_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] addr, input logic [15:0] data, input int t);
    exp_q.push_back({addr, data});
    exp_t_q.push_back(t);
  endtask

  // drivers: all called at a negedge and return at a negedge
  task automatic do_start(input logic [ADDR_W:0] wc);
    bus.start = 1'b1;
    bus.word_count = wc;
    @(negedge clk);
    bus.start = 1'b0;
    k0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.dbg_state != ST_IDLE && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.dbg_state != ST_IDLE) chk("idle_timeout", 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_error"},     32'(bus.error),     32'd0);
    chk({tag, "_state"},     32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      busy_hist[cyc % 1024] = bus.busy;
      checks++;
      if (bus.cpu_hold !== bus.busy) begin
        errors++;
        $display("FAIL cpu_hold act=%0b exp=%0b", bus.cpu_hold, bus.busy);
      end
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (bus.mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write act=%h_%h exp=none", bus.mem_addr, bus.mem_wdata);
        end else begin
          logic [31:0] e;
          int et;
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== e) begin
            errors++;
            $display("FAIL write act=%h_%h exp=%h_%h", bus.mem_addr, bus.mem_wdata,
                     e[31:16], e[15:0]);
          end
          if (et >= 0) begin
            checks++;
            if (cyc != et) begin
              errors++;
              $display("FAIL write_cycle act=%0d exp=%0d", cyc, et);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.abort = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;

    // reset values before any clock edge
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // two words, continuous stream, exact cycle timing
    do_start(5'd2);
    push_exp(16'h0000, 16'h1234, k0 + 2);
    push_exp(16'h0002, 16'hABCD, k0 + 5);
    dc = done_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("w2_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("w2_done_cyc", 32'(last_done_cyc), 32'(k0 + 6));
    chk("w2_busy_before", 32'(busy_hist[(k0 - 1) % 1024]), 32'd0);
    for (int i = 0; i <= 6; i++) chk("w2_busy", 32'(busy_hist[(k0 + i) % 1024]), 32'd1);
    chk("w2_busy_after", 32'(busy_hist[(k0 + 7) % 1024]), 32'd0);
    chk("w2_queue", 32'(exp_q.size()), 32'd0);

    // one word with a 5-cycle stall in LO
    do_start(5'd1);
    dc = done_cnt;
    send_byte(8'hBE);
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_state", 32'(bus.dbg_state), 32'(ST_LO));
    push_exp(16'h0000, 16'hBEEF, -1);
    send_byte(8'hEF);
    bus.rx_valid = 1'b0;
    wait_idle();
    chk("stall_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("stall_queue", 32'(exp_q.size()), 32'd0);

    // full depth: 16 words, word i = {10+i, C0+i}
    do_start(5'd16);
    dc = done_cnt;
    for (int i = 0; i < 16; i++)
      push_exp(16'(2 * i), {8'(8'h10 + i), 8'(8'hC0 + i)}, k0 + 2 + 3 * i);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h10 + i));
      send_byte(8'(8'hC0 + i));
    end
    bus.rx_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("full_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("full_queue", 32'(exp_q.size()), 32'd0);
    chk("full_last_addr", 32'(bus.mem_addr), 32'h001E);
    chk("full_last_data", 32'(bus.mem_wdata), 32'h1FCF);

    // abort while idle is ignored
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_error", 32'(bus.error), 32'd0);
    chk("idle_abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // illegal counts, then a legal start clears error
    do_start(5'd0);
    chk("cnt0_error", 32'(bus.error), 32'd1);
    chk("cnt0_busy", 32'(bus.busy), 32'd0);
    do_start(5'd17);
    chk("cnt17_error", 32'(bus.error), 32'd1);
    chk("cnt17_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    do_start(5'd1);
    chk("clr_error", 32'(bus.error), 32'd0);
    push_exp(16'h0000, 16'h5AA5, k0 + 2);
    send_byte(8'h5A);
    send_byte(8'hA5);
    bus.rx_valid = 1'b0;
    wait_idle();
    chk("clr_queue", 32'(exp_q.size()), 32'd0);

    // abort in LO of word 1 of 3
    do_start(5'd3);
    push_exp(16'h0000, 16'h0102, k0 + 2);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    chk("abort_pre_state", 32'(bus.dbg_state), 32'(ST_LO));
    bus.abort = 1'b1;
    bus.rx_data = 8'h04;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.rx_valid = 1'b0;
    chk("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("abort_error", 32'(bus.error), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);

    // reset while the write strobe is high
    do_start(5'd1);
    push_exp(16'h0000, 16'hCAFE, k0 + 2);
    send_byte(8'hCA);
    send_byte(8'hFE);
    bus.rx_valid = 1'b0;
    chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    do_start(5'd1);
    push_exp(16'h0000, 16'h0F0F, k0 + 2);
    send_byte(8'h0F);
    send_byte(8'h0F);
    bus.rx_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 4, giving the word-address width of the instruction memory (DEPTH = 2**ADDR_W words, 16 by default).
REQ-002 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port start, input, 1: requests a load session; sampled only in IDLE.
REQ-005 Port word_count, input, ADDR_W+1: number of 16-bit words to load; valid range 1..DEPTH.
REQ-006 Port abort, input, 1: synchronous cancel of an active session.
REQ-007 Port rx_data, input, 8: incoming program byte.
REQ-008 Port rx_valid, input, 1: rx_data is valid.
REQ-009 Port rx_ready, output, 1: loader accepts a byte; a transfer occurs on a cycle with rx_valid and rx_ready both high.
REQ-010 Port mem_we, output, 1: one-cycle write strobe to the instruction memory.
REQ-011 Port mem_addr, output, 16: byte address in PC format, bit 0 always 0, bits ADDR_W:1 = word index, upper bits 0.
REQ-012 Port mem_wdata, output, 16: instruction word to write.
REQ-013 Port busy, output, 1: a session is in progress.
REQ-014 Port cpu_hold, output, 1: holds the processor stalled; SHALL equal busy.
REQ-015 Port done, output, 1: one-cycle pulse on successful completion.
REQ-016 Port error, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL have states IDLE, HI, LO, WRITE, DONE, with all outputs decoded from registered state and registers (Moore).
REQ-018 IDLE: rx_ready=0, busy=0; on start with word_count in 1..DEPTH: clear error, latch word_count, word index=0, go to HI next cycle.
REQ-019 IDLE: on start with word_count=0 or >DEPTH: set error=1 and stay in IDLE; no write SHALL occur.
REQ-020 HI: rx_ready=1; on transfer: mem_wdata[15:8] <= rx_data, go to LO; otherwise hold.
REQ-021 LO: rx_ready=1; on transfer: mem_wdata[7:0] <= rx_data, go to WRITE; otherwise hold.
REQ-022 WRITE: mem_we=1 for exactly this cycle, rx_ready=0, mem_addr={index,1'b0}; if index==count-1 go to DONE, else increment index and go to HI.
REQ-023 DONE: done=1 for one cycle, busy=1; next state IDLE.
REQ-024 busy SHALL be 1 in HI, LO, WRITE and DONE.
REQ-025 Byte order SHALL be high byte first; byte timing has no limit, and stalls of any length on rx_valid SHALL NOT corrupt data.
REQ-026 Timing with continuous rx_valid and start sampled at edge k: bytes accepted in cycles k+1 and k+2, first write in cycle k+3, one word every 3 cycles, last write in cycle k+3N, done in cycle k+3N+1, IDLE in cycle k+3N+2.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 abort in HI, LO or WRITE SHALL suppress mem_we in that cycle, set error=1 and go to IDLE next cycle; abort in IDLE or DONE SHALL have no effect.
REQ-029 Index SHALL never exceed count-1; no write at or beyond DEPTH, and no wrap-around write, SHALL ever occur.
REQ-030 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-031 While rst=1, regardless of clock: state=IDLE, index=0, mem_wdata=0, mem_addr=0, mem_we=0, rx_ready=0, busy=0, cpu_hold=0, done=0, error=0.
REQ-032 Reset mid-session SHALL drop mem_we immediately and discard the partial session; after rst is released the block SHALL be in IDLE and waiting for start.

Verification
REQ-033 word_count=2, bytes 12,34,AB,CD with rx_valid held -> writes (0x0000,0x1234) at k+3 and (0x0002,0xABCD) at k+6; done at k+7; busy high k+1..k+7.
REQ-034 word_count=1, rx_valid low for 5 cycles in LO -> no write until the low byte arrives, then exactly one write with the correct word.
REQ-035 word_count=16 -> 16 writes, the last to 0x001E; no 17th write; done pulses once.
REQ-036 word_count=0, then word_count=17 -> error=1, busy=0, no mem_we; a following valid start clears error.
REQ-037 abort asserted in LO of word 1 (count=3) -> only word 0 written, error=1, IDLE next cycle.
REQ-038 rst asserted during WRITE -> mem_we=0 without waiting for a clock edge, all outputs at their reset values, IDLE after release.
